// File: rtl/lfsr_range_sampler.sv
// rtl/lfsr_range_sampler.sv - mask-and-reject range sampler for an LFSR stream with FWFT output FIFO
//
// Converts raw random words into unbiased integers in [0, N) and queues them
// for a ready/valid consumer. The random source cannot be stalled, so losses
// are counted rather than back-pressured.
//
// Optional feature macro: LFSR_RANGE_SAMPLER_STATS_EN
//   defined   : reject_cnt / drop_cnt are live saturating counters
//   undefined : counter registers omitted, ports tied to 0
//
// Ports (top):
//   clk                 system clock
//   rst                 synchronous active-high reset
//   random_number       raw LFSR word
//   random_number_valid random_number valid this cycle
//   range_n             bound N, 0 means 2^DATA_WIDTH
//   cfg_valid           load range_n when cfg_ready
//   cfg_ready           high in IDLE and RUN
//   out_data            sampled value in [0, N)
//   out_valid           FIFO not empty
//   out_ready           consumer accepts out_data
//   reject_cnt          rejected candidates, saturating
//   drop_cnt            accepted candidates lost to a full FIFO, saturating

module lfsr_range_sampler_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  push;
  logic                  pop;

  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign pop      = m_tvalid & m_tready;
  // Fullness is judged after the same-cycle pop, so a full FIFO being read
  // can still take a new entry.
  assign s_tready = (count != (AW+1)'(FIFO_DEPTH)) | pop;
  assign push     = s_tvalid & s_tready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared only by rst so out_data reads 0 out of reset; a flush
  // leaves stale data, which is harmless while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= s_tdata;
    end
  end
endmodule

module lfsr_range_sampler #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] random_number,
  input  logic                  random_number_valid,
  input  logic [DATA_WIDTH-1:0] range_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           reject_cnt,
  output logic [15:0]           drop_cnt
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  cfg_accept;

  logic [DATA_WIDTH-1:0] n_q;
  logic [DATA_WIDTH-1:0] nm1;
  logic                  n_zero;
  logic [DATA_WIDTH-1:0] mask;
  logic                  seen;
  logic                  scan_bit;
  logic [IW-1:0]         bit_idx;

  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_ok;
  logic                  s1_valid;
  logic                  s1_ok;
  logic [DATA_WIDTH-1:0] s1_cand;

  logic                  fifo_ready;
  logic                  fifo_push;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = CALC;
      end
      CALC: begin
        if (bit_idx == '0) state_d = RUN;
      end
      RUN: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_accept = cfg_valid & cfg_ready;
  assign nm1        = n_q - 1'b1;
  assign n_zero     = (n_q == '0);
  // Once the highest set bit of N-1 has been passed, every lower mask bit is 1.
  assign scan_bit   = seen | nm1[bit_idx];
  assign cand       = random_number & mask;
  assign cand_ok    = n_zero | (cand < n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      mask     <= '0;
      seen     <= 1'b0;
      bit_idx  <= '0;
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_cand  <= '0;
    end else if (cfg_accept) begin
      n_q      <= range_n;
      mask     <= '0;
      seen     <= 1'b0;
      bit_idx  <= IW'(DATA_WIDTH - 1);
      s1_valid <= 1'b0;
    end else begin
      if (state_q == CALC) begin
        mask[bit_idx] <= scan_bit;
        seen          <= scan_bit;
        bit_idx       <= bit_idx - 1'b1;
      end
      s1_valid <= (state_q == RUN) && random_number_valid;
      s1_ok    <= cand_ok;
      s1_cand  <= cand;
    end
  end

  // A config accept flushes stage 1 and the FIFO in the same edge, so the
  // stage-2 write it would race with is suppressed here.
  assign fifo_push = s1_valid & s1_ok & ~cfg_accept & fifo_ready;

  lfsr_range_sampler_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (cfg_accept),
    .s_tdata  (s1_cand),
    .s_tvalid (fifo_push),
    .s_tready (fifo_ready),
    .m_tdata  (out_data),
    .m_tvalid (out_valid),
    .m_tready (out_ready)
  );

`ifdef LFSR_RANGE_SAMPLER_STATS_EN
  logic rej_event;
  logic drop_event;

  assign rej_event  = s1_valid & ~s1_ok & ~cfg_accept;
  assign drop_event = s1_valid & s1_ok & ~fifo_ready & ~cfg_accept;

  always_ff @(posedge clk) begin
    if (rst || cfg_accept) begin
      reject_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (rej_event && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 1'b1;
      if (drop_event && drop_cnt != 16'hFFFF)  drop_cnt   <= drop_cnt + 1'b1;
    end
  end
`else
  assign reject_cnt = '0;
  assign drop_cnt   = '0;
`endif
endmodule
